// File: rtl/fft_reorder_buf_if.sv
`default_nettype none
// =============================================================================
// fft_reorder_buf_if : paired-sample input stream and natural-order output stream
// Rev 1.0
// =============================================================================
interface fft_reorder_buf_if #(
    parameter int N        = 18,
    parameter int LOG2_PTS = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic signed [N:0]         in0_r;
    logic signed [N:0]         in0_i;
    logic signed [N:0]         in1_r;
    logic signed [N:0]         in1_i;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic signed [N-1:0]       out_r;
    logic signed [N-1:0]       out_i;
    logic [LOG2_PTS-1:0]       out_idx;

    // master: upstream butterfly plus downstream consumer; slave: the reorder buffer
    modport master (
        output in_valid, in_last, in0_r, in0_i, in1_r, in1_i, out_ready,
        input  in_ready, out_valid, out_last, out_r, out_i, out_idx
    );
    modport slave (
        input  in_valid, in_last, in0_r, in0_i, in1_r, in1_i, out_ready,
        output in_ready, out_valid, out_last, out_r, out_i, out_idx
    );
endinterface
`default_nettype wire

// File: rtl/fft_reorder_buf.sv
`default_nettype none
// =============================================================================
// fft_reorder_buf : bit-reversed butterfly pairs -> natural-order stream via
//                   ping-pong banks. FFT_REORDER_ROUND_EN selects round-half-up.
// Rev 1.0
// =============================================================================
module fft_reorder_buf #(
    parameter int N        = 18,
    parameter int LOG2_PTS = 3
) (
    input  logic              clk,
    input  logic              rst,
    fft_reorder_buf_if.slave  bus,
    output logic              err
);
    localparam int P  = 1 << LOG2_PTS;
    localparam int KW = LOG2_PTS - 1;
    localparam logic [KW-1:0]       K_LAST   = {KW{1'b1}};
    localparam logic [LOG2_PTS-1:0] IDX_LAST = {LOG2_PTS{1'b1}};

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

    logic signed [N:0] mem_r [2*P];
    logic signed [N:0] mem_i [2*P];

    bank_state_t          bank_st_q [2];
    bank_state_t          bank_st_d [2];
    logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, ld_bank_q, ld_bank_d;
    logic [KW-1:0]        k_q, k_d;
    logic [LOG2_PTS-1:0]  ld_idx_q, ld_idx_d;
    logic                 in_ready_q, in_ready_d, err_q, err_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic signed [N-1:0]  out_r_q, out_r_d, out_i_q, out_i_d;
    logic [LOG2_PTS-1:0]  out_idx_q, out_idx_d;

    logic                 w_accept, w_frame_done, w_xfer, w_drained, w_src_full, w_load;
    logic [LOG2_PTS-1:0]  w_addr0, w_addr1;
    logic [LOG2_PTS:0]    w_rd_addr;

    function automatic logic [LOG2_PTS-1:0] bitrev(input logic [LOG2_PTS-1:0] a);
        logic [LOG2_PTS-1:0] r;
        for (int b = 0; b < LOG2_PTS; b++) r[b] = a[LOG2_PTS-1-b];
        return r;
    endfunction

    function automatic logic signed [N-1:0] scale_half(input logic signed [N:0] x);
`ifdef FFT_REORDER_ROUND_EN
        logic [N+1:0] s;
        s = {x[N], x} + (N+2)'(1);
        // only +2^(N-1) can overflow after the rounding increment
        if (s[N+1:N] == 2'b01) return {1'b0, {(N-1){1'b1}}};
        return s[N:1];
`else
        return x[N:1];
`endif
    endfunction

    // bitrev(2k) always has a clear MSB, so the partner slot just sets it
    assign w_addr0   = bitrev({k_q, 1'b0});
    assign w_addr1   = {1'b1, w_addr0[LOG2_PTS-2:0]};
    assign w_rd_addr = {ld_bank_q, ld_idx_q};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_r[{wr_bank_q, w_addr0}] <= bus.in0_r;
            mem_i[{wr_bank_q, w_addr0}] <= bus.in0_i;
            mem_r[{wr_bank_q, w_addr1}] <= bus.in1_r;
            mem_i[{wr_bank_q, w_addr1}] <= bus.in1_i;
        end
    end

    always_comb begin
        bank_st_d   = bank_st_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        ld_bank_d   = ld_bank_q;
        k_d         = k_q;
        ld_idx_d    = ld_idx_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_idx_d   = out_idx_q;

        w_accept     = bus.in_valid && in_ready_q;
        w_frame_done = w_accept && (k_q == K_LAST);
        w_xfer       = out_valid_q && bus.out_ready;
        w_drained    = w_xfer && out_last_q;
        // a bank completing on this edge may feed the output register immediately
        w_src_full   = (bank_st_q[ld_bank_q] == FULL) || (w_frame_done && (wr_bank_q == ld_bank_q));
        w_load       = w_src_full && (!out_valid_q || bus.out_ready);

        if (w_accept) begin
            if (bus.in_last != (k_q == K_LAST)) err_d = 1'b1;
            if (k_q == K_LAST) begin
                k_d                  = '0;
                bank_st_d[wr_bank_q] = FULL;
                wr_bank_d            = !wr_bank_q;
            end else begin
                k_d = k_q + 1'b1;
            end
        end

        if (w_drained) begin
            bank_st_d[rd_bank_q] = EMPTY;
            rd_bank_d            = !rd_bank_q;
        end

        if (w_load) begin
            out_valid_d = 1'b1;
            out_r_d     = scale_half(mem_r[w_rd_addr]);
            out_i_d     = scale_half(mem_i[w_rd_addr]);
            out_idx_d   = ld_idx_q;
            out_last_d  = (ld_idx_q == IDX_LAST);
            ld_idx_d    = ld_idx_q + 1'b1;
            if (ld_idx_q == IDX_LAST) ld_bank_d = !ld_bank_q;
        end else if (w_xfer) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = (bank_st_d[wr_bank_d] == EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            ld_bank_q    <= 1'b0;
            k_q          <= '0;
            ld_idx_q     <= '0;
            in_ready_q   <= 1'b0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_r_q      <= '0;
            out_i_q      <= '0;
            out_idx_q    <= '0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            ld_bank_q    <= ld_bank_d;
            k_q          <= k_d;
            ld_idx_q     <= ld_idx_d;
            in_ready_q   <= in_ready_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_r_q      <= out_r_d;
            out_i_q      <= out_i_d;
            out_idx_q    <= out_idx_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_idx   = out_idx_q;
    assign err           = err_q;
endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_buf.sv
`default_nettype none
// =============================================================================
// tb_fft_reorder_buf : directed self-checking bench, N=18, P=8
// Rev 1.0
// =============================================================================
module tb_fft_reorder_buf;
    typedef int frame_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int   n_checks = 0;
    int   n_fail   = 0;
    // natural-order raw values for a frame with base 0 (beat k carries 10k, 10k+1)
    frame_t nat_tab = '{0, 20, 10, 30, 1, 21, 11, 31};

    fft_reorder_buf_if #(.N(18), .LOG2_PTS(3)) bus ();

    fft_reorder_buf #(.N(18), .LOG2_PTS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sc(input int x);
`ifdef FFT_REORDER_ROUND_EN
        int y;
        y = (x + 1) >>> 1;
        if (y > 131071) y = 131071;
        return y;
`else
        return x >>> 1;
`endif
    endfunction

    task automatic mk_frame(input int base, output frame_t beats, output frame_t nat);
        for (int k = 0; k < 4; k++) begin
            beats[2*k]   = base + 10*k;
            beats[2*k+1] = base + 10*k + 1;
        end
        for (int i = 0; i < 8; i++) nat[i] = base + nat_tab[i];
    endtask

    task automatic send_frame(input frame_t beats, input int last_pos, output bit pre_valid);
        int waited;
        pre_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waited       = 0;
            bus.in_valid = 1'b1;
            bus.in0_r    = 19'(beats[2*k]);
            bus.in0_i    = 19'(-beats[2*k]);
            bus.in1_r    = 19'(beats[2*k+1]);
            bus.in1_i    = 19'(-beats[2*k+1]);
            bus.in_last  = (k == last_pos);
            while (bus.in_ready !== 1'b1 && waited < 100) begin
                tick();
                waited++;
            end
            if (bus.in_ready !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout beat=%0d in_ready=%b required=1", k, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            if (k == 3) pre_valid = bus.out_valid;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect(input frame_t nat, input bit toggle, input bit strict);
        int got = 0, cyc = 0, hr = 0, hi = 0, hidx = 0;
        bit rdy, stalled = 1'b0;
        while (got < 8 && cyc < 200) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.out_ready = rdy;
            if (stalled) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || int'(bus.out_r) !== hr || int'(bus.out_i) !== hi ||
                    int'(bus.out_idx) !== hidx) begin
                    n_fail++;
                    $display("FAIL hold_stable v=%b r=%0d i=%0d idx=%0d required v=1 r=%0d i=%0d idx=%0d",
                             bus.out_valid, bus.out_r, bus.out_i, bus.out_idx, hr, hi, hidx);
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (rdy) begin
                    n_checks++;
                    if (int'(bus.out_idx) !== got || int'(bus.out_r) !== sc(nat[got]) ||
                        int'(bus.out_i) !== sc(-nat[got]) || bus.out_last !== (got == 7)) begin
                        n_fail++;
                        $display("FAIL sample idx=%0d r=%0d i=%0d last=%b required idx=%0d r=%0d i=%0d last=%b",
                                 bus.out_idx, bus.out_r, bus.out_i, bus.out_last,
                                 got, sc(nat[got]), sc(-nat[got]), (got == 7));
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hr      = int'(bus.out_r);
                    hi      = int'(bus.out_i);
                    hidx    = int'(bus.out_idx);
                end
            end else if (strict) begin
                n_checks++;
                n_fail++;
                $display("FAIL bubble at sample %0d out_valid=%b required=1", got, bus.out_valid);
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (got < 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL collect_timeout got=%0d required=8", got);
        end
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus.in0_r = '0; bus.in0_i = '0; bus.in1_r = '0; bus.in1_i = '0;
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags in_ready=%b out_valid=%b err=%b required 0 0 0",
                     bus.in_ready, bus.out_valid, err);
        end
        n_checks++;
        if (bus.out_r !== '0 || bus.out_i !== '0 || bus.out_idx !== '0 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data r=%0d i=%0d idx=%0d last=%b required 0 0 0 0",
                     bus.out_r, bus.out_i, bus.out_idx, bus.out_last);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release in_ready=%b required=1", bus.in_ready);
        end
    endtask

    task automatic test_single_frame;
        frame_t b, n;
        bit pv;
        bus.out_ready = 1'b0;
        mk_frame(0, b, n);
        send_frame(b, 3, pv);
        n_checks++;
        if (pv !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL first_latency before=%b after=%b idx=%0d required 0 1 0",
                     pv, bus.out_valid, bus.out_idx);
        end
        collect(n, 1'b0, 1'b1);
    endtask

    task automatic test_back_pressure;
        frame_t b, n;
        bit pv;
        mk_frame(40, b, n);
        send_frame(b, 3, pv);
        collect(n, 1'b1, 1'b0);
    endtask

    task automatic test_ping_pong;
        frame_t b1, n1, b2, n2, b3, n3;
        bit pv;
        bus.out_ready = 1'b0;
        mk_frame(100, b1, n1);
        mk_frame(200, b2, n2);
        mk_frame(300, b3, n3);
        send_frame(b1, 3, pv);
        send_frame(b2, 3, pv);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL both_full in_ready=%b required=0", bus.in_ready);
        end
        repeat (3) tick();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL stalled_hold in_ready=%b out_valid=%b idx=%0d required 0 1 0",
                     bus.in_ready, bus.out_valid, bus.out_idx);
        end
        fork
            send_frame(b3, 3, pv);
            begin
                collect(n1, 1'b0, 1'b1);
                collect(n2, 1'b0, 1'b1);
            end
        join
        collect(n3, 1'b0, 1'b0);
    endtask

    task automatic test_framing_err;
        frame_t b, n;
        bit pv;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean err=%b required=0", err);
        end
        mk_frame(500, b, n);
        send_frame(b, 1, pv);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set err=%b required=1", err);
        end
        collect(n, 1'b0, 1'b1);
        mk_frame(600, b, n);
        send_frame(b, 3, pv);
        collect(n, 1'b0, 1'b1);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky err=%b required=1", err);
        end
    endtask

    task automatic test_rounding;
        frame_t b = '{262143, 3, 0, 0, 0, 0, 0, 0};
        frame_t n = '{262143, 0, 0, 0, 3, 0, 0, 0};
        bit pv;
        send_frame(b, 3, pv);
        n_checks++;
        if (int'(bus.out_r) !== 131071) begin
            n_fail++;
            $display("FAIL max_positive r=%0d required=131071", bus.out_r);
        end
        collect(n, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_drain;
        frame_t b, n;
        bit pv, seen = 1'b0;
        mk_frame(700, b, n);
        send_frame(b, 3, pv);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_idx v=%b idx=%0d required 1 3", bus.out_valid, bus.out_idx);
        end
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset out_valid=%b in_ready=%b required 0 0", bus.out_valid, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset in_ready=%b out_valid=%b err=%b required 1 0 0",
                     bus.in_ready, bus.out_valid, err);
        end
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL stale_output seen=%b required=0", seen);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_ping_pong();
        test_framing_err();
        test_rounding();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
